// File: rtl/neo_pkg.sv
// Shared FSM state type and result-width helper for the NEO sequencer.
package neo_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        CALC = 3'd4,
        OUT  = 3'd5
    } neo_state_t;

    function automatic int psi_width(input int n);
        return 2 * n + 1;
    endfunction

endpackage

// File: rtl/neo_if.sv
// Sample stream, sample-memory port and psi result stream of the NEO sequencer.
interface neo_if #(
    parameter int N = 16,
    parameter int M = 16
);
    import neo_pkg::*;

    localparam int AW = $clog2(M);
    localparam int PW = psi_width(N);

    logic                 s_valid;
    logic                 s_ready;
    logic signed [N-1:0]  s_data;
    logic                 mem_we;
    logic [AW-1:0]        waddr;
    logic signed [N-1:0]  wdata;
    logic [AW-1:0]        raddr;
    logic signed [N-1:0]  rdata;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [PW-1:0] m_data;

    modport slave (
        input  s_valid, s_data, rdata, m_ready,
        output s_ready, mem_we, waddr, wdata, raddr, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, rdata, m_ready,
        input  s_ready, mem_we, waddr, wdata, raddr, m_valid, m_data
    );

endinterface

// File: rtl/neo_psi_core.sv
// Registered psi = xc^2 - xp*xn in full 2N+1-bit signed precision.
// Build option: NEO_CLAMP_EN clamps negative results to zero.
module neo_psi_core
    import neo_pkg::*;
#(
    parameter  int N  = 16,
    localparam int PW = psi_width(N)
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic signed [N-1:0]  xp,
    input  logic signed [N-1:0]  xc,
    input  logic signed [N-1:0]  xn,
    output logic signed [PW-1:0] psi
);

    logic signed [PW-1:0] sp, sc, sn, diff, psi_nxt;

    assign sp   = xp;
    assign sc   = xc;
    assign sn   = xn;
    assign diff = sc * sc - sp * sn;

`ifdef NEO_CLAMP_EN
    assign psi_nxt = diff[PW-1] ? '0 : diff;
`else
    assign psi_nxt = diff;
`endif

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            psi <= '0;
        else if (load)
            psi <= psi_nxt;
    end

endmodule

// File: rtl/neo_sequencer.sv
// NEO sequencer: writes samples to the circular memory, reads x[n-1], x[n], x[n+1]
// and streams psi. Build option NEO_CLAMP_EN (see neo_psi_core).
//   state | meaning
//   IDLE  | waiting for at least three unconsumed samples
//   RD0   | address x[n-1]
//   RD1   | address x[n], capture x[n-1]
//   RD2   | address x[n+1], capture x[n]
//   CALC  | x[n+1] on rdata, psi registered
//   OUT   | m_valid high until downstream handshake
module neo_sequencer
    import neo_pkg::*;
#(
    parameter  int N  = 16,
    parameter  int M  = 16,
    localparam int AW = $clog2(M)
) (
    input  logic       Clk,
    input  logic       reset,
    neo_if.slave       bus,
    output logic [AW:0] occupancy,
    output logic       busy
);

    neo_state_t          state, state_nxt;
    logic [AW-1:0]       wptr, rptr;
    logic signed [N-1:0] xp, xc;
    logic                accept, pop, load;
    logic [AW:0]         occ_after;

    assign bus.s_ready = (occupancy < (AW+1)'(M));
    assign accept      = bus.s_valid & bus.s_ready;
    assign pop         = (state == OUT) & bus.m_ready;
    assign occ_after   = occupancy + (AW+1)'(accept) - (AW+1)'(pop);

    assign bus.mem_we  = accept;
    assign bus.waddr   = wptr;
    assign bus.wdata   = accept ? bus.s_data : '0;
    assign busy        = (state != IDLE);

    // Occupancy never exceeds M, so wptr cannot land on the rptr..rptr+2 window in use.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            occupancy <= '0;
        end else begin
            if (accept)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            occupancy <= occ_after;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (occupancy >= (AW+1)'(3)) state_nxt = RD0;
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     if (bus.m_ready) state_nxt = (occ_after >= (AW+1)'(3)) ? RD0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.raddr   = rptr;
        bus.m_valid = 1'b0;
        load        = 1'b0;
        case (state)
            RD1:     bus.raddr = rptr + AW'(1);
            RD2:     bus.raddr = rptr + AW'(2);
            CALC:    load = 1'b1;
            OUT:     bus.m_valid = 1'b1;
            default: ;
        endcase
    end

    // Synchronous-read memory: each sample lands one state after its address.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            xp <= '0;
            xc <= '0;
        end else begin
            if (state == RD1)
                xp <= bus.rdata;
            if (state == RD2)
                xc <= bus.rdata;
        end
    end

    neo_psi_core #(.N(N)) u_core (
        .Clk   (Clk),
        .reset (reset),
        .load  (load),
        .xp    (xp),
        .xc    (xc),
        .xn    (bus.rdata),
        .psi   (bus.m_data)
    );

endmodule
